mac_bus_responder: RTL and testbench

Active 68000 bus slave for the Mac Plus VGA board: decodes CPU cycles that hit the board's 256 KB SRAM window, claims SRAM only in the access slots the video timing logic releases, and completes the bus cycle with nDTACK. It drives read data back onto D. It sits between the 68000 bus pins and the shared SRAM port, alongside the passive write snooper and video fetch logic.

---
 rtl/mac_bus_responder_if.sv | 44 ++++
 rtl/mac_bus_responder.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_mac_bus_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_bus_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_bus_responder_if
//  Description : 68000 bus-side and SRAM-side signal bundle for the Mac Plus
//                VGA board bus responder. The slave modport is the responder's
//                view; the master modport is the view of the surrounding
//                CPU bus, SRAM and video timing.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_bus_responder_if;
  // 68000 side
  logic [23:1] A;
  logic [15:0] Din;
  logic [15:0] Dout;
  logic        Doe;
  logic        nAS;
  logic        nLDS;
  logic        nUDS;
  logic        nWE;
  logic        nDTACK;
  logic        nBERR;
  // Video timing side
  logic        CPUSlot;
  logic        Busy;
  // SRAM side
  logic [16:0] RA;
  logic [15:0] RDin;
  logic [15:0] RDout;
  logic        RDoe;
  logic        nRCSL;
  logic        nRCSH;
  logic        nRWE;

  modport slave (
    input  A, Din, nAS, nLDS, nUDS, nWE, CPUSlot, RDin,
    output Dout, Doe, nDTACK, nBERR, Busy, RA, RDout, RDoe, nRCSL, nRCSH, nRWE
  );

  modport master (
    output A, Din, nAS, nLDS, nUDS, nWE, CPUSlot, RDin,
    input  Dout, Doe, nDTACK, nBERR, Busy, RA, RDout, RDoe, nRCSL, nRCSH, nRWE
  );
endinterface
`default_nettype wire

// File: rtl/mac_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mac_bus_responder
//  Description : Active 68000 bus slave for the board's 256 KB SRAM window.
//                Decodes CPU cycles hitting A[23:18] == BASE, waits for a
//                CPU access slot released by the video timing, runs a
//                single-cycle-strobe SRAM access, then completes the 68000
//                cycle with nDTACK (and drives read data onto D).
//  Options     : RESP_TIMEOUT_EN - bus error (nBERR) if no CPU slot arrives
//                within TIMEOUT clocks of waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_bus_responder #(
  parameter logic [5:0] BASE    = 6'h0F
`ifdef RESP_TIMEOUT_EN
  , parameter logic [7:0] TIMEOUT = 8'd64
`endif
) (
  input  wire logic          C25M,
  input  wire logic          nRST,
  mac_bus_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    WAIT_SLOT = 3'd2,
    SETUP     = 3'd3,
    STROBE    = 3'd4,
    LATCH     = 3'd5,
    ACK       = 3'd6,
    RELEASE   = 3'd7
  } state_t;

  // Synchronizer chains, bit 1 is the synchronized (usable) value
  logic [1:0]  r_asSync;
  logic [1:0]  r_ldsSync;
  logic [1:0]  r_udsSync;
  logic [1:0]  r_weSync;
  logic        w_sAs;
  logic        w_sLds;
  logic        w_sUds;
  logic        w_sWe;

  // FSM state and captured CPU cycle
  state_t      r_state;
  state_t      w_stateNext;
  logic [16:0] r_addr;
  logic [16:0] w_addrNext;
  logic [15:0] r_wdata;
  logic [15:0] w_wdataNext;
  logic        r_isWrite;
  logic        w_isWriteNext;
  logic        r_ldsN;
  logic        w_ldsNNext;
  logic        r_udsN;
  logic        w_udsNNext;

  // Registered outputs
  logic [15:0] r_dout;
  logic [15:0] w_doutNext;
  logic        r_oe;
  logic        w_oeNext;
  logic        r_dtackN;
  logic        w_dtackNNext;
  logic [16:0] r_ra;
  logic [16:0] w_raNext;
  logic [15:0] r_rdout;
  logic [15:0] w_rdoutNext;
  logic        r_rdoe;
  logic        w_rdoeNext;
  logic        r_rcslN;
  logic        w_rcslNNext;
  logic        r_rcshN;
  logic        w_rcshNNext;
  logic        r_rweN;
  logic        w_rweNNext;
  logic        r_busy;

`ifdef RESP_TIMEOUT_EN
  logic        r_berrN;
  logic        w_berrNNext;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cntNext;
`endif

  // Bring the asynchronous 68000 strobes into the C25M domain
  always_ff @(posedge C25M or negedge nRST) begin
    if (!nRST) begin
      r_asSync  <= 2'b11;
      r_ldsSync <= 2'b11;
      r_udsSync <= 2'b11;
      r_weSync  <= 2'b11;
    end else begin
      r_asSync  <= {r_asSync[0],  bus.nAS};
      r_ldsSync <= {r_ldsSync[0], bus.nLDS};
      r_udsSync <= {r_udsSync[0], bus.nUDS};
      r_weSync  <= {r_weSync[0],  bus.nWE};
    end
  end

  assign w_sAs  = r_asSync[1];
  assign w_sLds = r_ldsSync[1];
  assign w_sUds = r_udsSync[1];
  assign w_sWe  = r_weSync[1];

  // Next-state and next-output decode; every register holds unless changed
  always_comb begin
    w_stateNext   = r_state;
    w_addrNext    = r_addr;
    w_wdataNext   = r_wdata;
    w_isWriteNext = r_isWrite;
    w_ldsNNext    = r_ldsN;
    w_udsNNext    = r_udsN;
    w_doutNext    = r_dout;
    w_oeNext      = r_oe;
    w_dtackNNext  = r_dtackN;
    w_raNext      = r_ra;
    w_rdoutNext   = r_rdout;
    w_rdoeNext    = r_rdoe;
    w_rcslNNext   = r_rcslN;
    w_rcshNNext   = r_rcshN;
    w_rweNNext    = r_rweN;
`ifdef RESP_TIMEOUT_EN
    w_berrNNext   = r_berrN;
    w_cntNext     = r_cnt;
`endif

    case (r_state)
      IDLE: begin
        if (!w_sAs) begin
          w_stateNext = DECODE;
        end
      end

      DECODE: begin
        if (w_sAs) begin
          // CPU gave up the cycle before we committed to anything
          w_stateNext = IDLE;
        end else if (bus.A[23:18] != BASE) begin
          // Not our window: stay off the bus until the cycle ends
          w_stateNext = RELEASE;
        end else if (w_sWe) begin
          w_addrNext    = bus.A[17:1];
          w_isWriteNext = 1'b0;
          w_stateNext   = WAIT_SLOT;
`ifdef RESP_TIMEOUT_EN
          w_cntNext     = 8'd0;
`endif
        end else if (!w_sLds || !w_sUds) begin
          // Data strobes have been low for two clocks, so the raw bus
          // lines they qualify are settled and safe to capture here
          w_addrNext    = bus.A[17:1];
          w_wdataNext   = bus.Din;
          w_ldsNNext    = bus.nLDS;
          w_udsNNext    = bus.nUDS;
          w_isWriteNext = 1'b1;
          w_stateNext   = WAIT_SLOT;
`ifdef RESP_TIMEOUT_EN
          w_cntNext     = 8'd0;
`endif
        end
      end

      WAIT_SLOT: begin
        if (w_sAs) begin
          w_stateNext = IDLE;
        end else if (bus.CPUSlot) begin
          // Address, direction and write data go out one clock ahead of CS
          w_raNext    = r_addr;
          w_rweNNext  = ~r_isWrite;
          w_rdoeNext  = r_isWrite;
          if (r_isWrite) begin
            w_rdoutNext = r_wdata;
          end
          w_stateNext = SETUP;
        end
`ifdef RESP_TIMEOUT_EN
        else if (r_cnt == TIMEOUT - 8'd1) begin
          w_berrNNext = 1'b0;
          w_stateNext = ACK;
        end else begin
          w_cntNext = r_cnt + 8'd1;
        end
`endif
      end

      SETUP: begin
        w_rcslNNext = r_isWrite ? r_ldsN : 1'b0;
        w_rcshNNext = r_isWrite ? r_udsN : 1'b0;
        w_stateNext = STROBE;
      end

      STROBE: begin
        // SRAM cycle always finishes here, even if the CPU has aborted
        w_rcslNNext = 1'b1;
        w_rcshNNext = 1'b1;
        w_rweNNext  = 1'b1;
        w_rdoeNext  = 1'b0;
        if (!r_isWrite) begin
          w_doutNext = bus.RDin;
        end
        w_stateNext = w_sAs ? RELEASE : LATCH;
      end

      LATCH: begin
        w_dtackNNext = 1'b0;
        w_oeNext     = ~r_isWrite;
        w_stateNext  = ACK;
      end

      ACK: begin
        if (w_sAs) begin
          w_dtackNNext = 1'b1;
          w_oeNext     = 1'b0;
`ifdef RESP_TIMEOUT_EN
          w_berrNNext  = 1'b1;
`endif
          w_stateNext  = RELEASE;
        end
      end

      RELEASE: begin
        w_dtackNNext = 1'b1;
        w_oeNext     = 1'b0;
`ifdef RESP_TIMEOUT_EN
        w_berrNNext  = 1'b1;
`endif
        if (w_sAs) begin
          w_stateNext = IDLE;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State, captured cycle and registered outputs
  always_ff @(posedge C25M or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_addr    <= 17'd0;
      r_wdata   <= 16'd0;
      r_isWrite <= 1'b0;
      r_ldsN    <= 1'b1;
      r_udsN    <= 1'b1;
      r_dout    <= 16'd0;
      r_oe      <= 1'b0;
      r_dtackN  <= 1'b1;
      r_ra      <= 17'd0;
      r_rdout   <= 16'd0;
      r_rdoe    <= 1'b0;
      r_rcslN   <= 1'b1;
      r_rcshN   <= 1'b1;
      r_rweN    <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_addr    <= w_addrNext;
      r_wdata   <= w_wdataNext;
      r_isWrite <= w_isWriteNext;
      r_ldsN    <= w_ldsNNext;
      r_udsN    <= w_udsNNext;
      r_dout    <= w_doutNext;
      r_oe      <= w_oeNext;
      r_dtackN  <= w_dtackNNext;
      r_ra      <= w_raNext;
      r_rdout   <= w_rdoutNext;
      r_rdoe    <= w_rdoeNext;
      r_rcslN   <= w_rcslNNext;
      r_rcshN   <= w_rcshNNext;
      r_rweN    <= w_rweNNext;
      r_busy    <= (w_stateNext != IDLE);
    end
  end

`ifdef RESP_TIMEOUT_EN
  // Slot-wait timeout counter and bus error output
  always_ff @(posedge C25M or negedge nRST) begin
    if (!nRST) begin
      r_berrN <= 1'b1;
      r_cnt   <= 8'd0;
    end else begin
      r_berrN <= w_berrNNext;
      r_cnt   <= w_cntNext;
    end
  end

  assign bus.nBERR = r_berrN;
`else
  assign bus.nBERR = 1'b1;
`endif

  // D is released the moment the CPU drops AS, without waiting for the FSM
  assign bus.Doe    = r_oe & ~bus.nAS;
  assign bus.Dout   = r_dout;
  assign bus.nDTACK = r_dtackN;
  assign bus.Busy   = r_busy;
  assign bus.RA     = r_ra;
  assign bus.RDout  = r_rdout;
  assign bus.RDoe   = r_rdoe;
  assign bus.nRCSL  = r_rcslN;
  assign bus.nRCSH  = r_rcshN;
  assign bus.nRWE   = r_rweN;

endmodule
`default_nettype wire

// File: tb/tb_mac_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_bus_responder
//  Description : Directed self-checking bench for mac_bus_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_bus_responder;

  logic C25M;
  logic nRST;
  int   nChecks;
  int   nPass;
  int   csLTotal;
  int   csHTotal;
  int   dtackTotal;

  mac_bus_responder_if bus ();

  mac_bus_responder dut (
    .C25M (C25M),
    .nRST (nRST),
    .bus  (bus)
  );

  initial C25M = 1'b0;
  always #20 C25M = ~C25M;

  // Count clocks during which each active-low strobe is asserted
  always @(negedge C25M) begin
    if (bus.nRCSL === 1'b0) csLTotal++;
    if (bus.nRCSH === 1'b0) csHTotal++;
    if (bus.nDTACK === 1'b0) dtackTotal++;
  end

  // Begin a 68000 cycle on a falling clock edge
  task automatic cpu_start(input logic [23:0] byteAddr, input logic isWrite,
                           input logic [15:0] data, input logic ldsN, input logic udsN);
    @(negedge C25M);
    bus.A    = byteAddr[23:1];
    bus.nWE  = ~isWrite;
    bus.Din  = data;
    bus.nLDS = ldsN;
    bus.nUDS = udsN;
    bus.nAS  = 1'b0;
  endtask

  task automatic cpu_end();
    bus.nAS  = 1'b1;
    bus.nLDS = 1'b1;
    bus.nUDS = 1'b1;
    bus.nWE  = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(negedge C25M);
    #1;
    nChecks++; if (bus.nDTACK !== 1'b1) $display("FAIL rst_nDTACK: got %b want 1", bus.nDTACK); else nPass++;
    nChecks++; if (bus.nBERR !== 1'b1) $display("FAIL rst_nBERR: got %b want 1", bus.nBERR); else nPass++;
    nChecks++; if (bus.Doe !== 1'b0) $display("FAIL rst_Doe: got %b want 0", bus.Doe); else nPass++;
    nChecks++; if (bus.Dout !== 16'h0000) $display("FAIL rst_Dout: got %h want 0000", bus.Dout); else nPass++;
    nChecks++; if (bus.RA !== 17'h00000) $display("FAIL rst_RA: got %h want 00000", bus.RA); else nPass++;
    nChecks++; if (bus.RDout !== 16'h0000) $display("FAIL rst_RDout: got %h want 0000", bus.RDout); else nPass++;
    nChecks++; if (bus.RDoe !== 1'b0) $display("FAIL rst_RDoe: got %b want 0", bus.RDoe); else nPass++;
    nChecks++; if ({bus.nRCSL, bus.nRCSH} !== 2'b11) $display("FAIL rst_cs: got %b want 11", {bus.nRCSL, bus.nRCSH}); else nPass++;
    nChecks++; if (bus.nRWE !== 1'b1) $display("FAIL rst_nRWE: got %b want 1", bus.nRWE); else nPass++;
    nChecks++; if (bus.Busy !== 1'b0) $display("FAIL rst_Busy: got %b want 0", bus.Busy); else nPass++;
    @(negedge C25M);
    nRST = 1'b1;
    repeat (2) @(negedge C25M);
  endtask

  task automatic test_read_hit();
    int csL0, csH0;
    csL0 = csLTotal;
    csH0 = csHTotal;
    bus.RDin = 16'hBEEF;
    cpu_start(24'h3FA700, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (5) @(negedge C25M);
    bus.CPUSlot = 1'b1;
    @(posedge C25M); #1;
    bus.CPUSlot = 1'b0;
    nChecks++; if (bus.RA !== 17'h1D380) $display("FAIL rd_RA: got %h want 1d380", bus.RA); else nPass++;
    nChecks++; if ({bus.nRWE, bus.RDoe, bus.nRCSL} !== 3'b101) $display("FAIL rd_setup: got nRWE/RDoe/nRCSL=%b want 101", {bus.nRWE, bus.RDoe, bus.nRCSL}); else nPass++;
    nChecks++; if (bus.Busy !== 1'b1) $display("FAIL rd_Busy: got %b want 1", bus.Busy); else nPass++;
    @(posedge C25M); #1;
    nChecks++; if ({bus.nRCSL, bus.nRCSH, bus.nDTACK} !== 3'b001) $display("FAIL rd_cs_low: got %b want 001", {bus.nRCSL, bus.nRCSH, bus.nDTACK}); else nPass++;
    @(posedge C25M); #1;
    bus.RDin = 16'h0000;
    nChecks++; if ({bus.nRCSL, bus.nRCSH, bus.nDTACK} !== 3'b111) $display("FAIL rd_cs_high: got %b want 111", {bus.nRCSL, bus.nRCSH, bus.nDTACK}); else nPass++;
    nChecks++; if (bus.Dout !== 16'hBEEF) $display("FAIL rd_Dout_capture: got %h want beef", bus.Dout); else nPass++;
    @(posedge C25M); #1;
    nChecks++; if (bus.nDTACK !== 1'b0) $display("FAIL rd_dtack_latency: got %b want 0", bus.nDTACK); else nPass++;
    nChecks++; if (bus.Doe !== 1'b1) $display("FAIL rd_Doe: got %b want 1", bus.Doe); else nPass++;
    repeat (3) @(posedge C25M); #1;
    nChecks++; if ({bus.nDTACK, bus.Dout} !== {1'b0, 16'hBEEF}) $display("FAIL rd_hold: got %b/%h want 0/beef", bus.nDTACK, bus.Dout); else nPass++;
    @(negedge C25M);
    cpu_end();
    #1;
    nChecks++; if ({bus.Doe, bus.nDTACK} !== 2'b00) $display("FAIL rd_Doe_release: got Doe/nDTACK=%b want 00", {bus.Doe, bus.nDTACK}); else nPass++;
    repeat (2) @(posedge C25M); #1;
    nChecks++; if (bus.nDTACK !== 1'b0) $display("FAIL rd_dtack_early: got %b want 0", bus.nDTACK); else nPass++;
    @(posedge C25M); #1;
    nChecks++; if (bus.nDTACK !== 1'b1) $display("FAIL rd_dtack_release: got %b want 1", bus.nDTACK); else nPass++;
    repeat (2) @(posedge C25M); #1;
    nChecks++; if (bus.Busy !== 1'b0) $display("FAIL rd_Busy_end: got %b want 0", bus.Busy); else nPass++;
    nChecks++; if ((csLTotal - csL0) !== 1 || (csHTotal - csH0) !== 1) $display("FAIL rd_cs_width: got %0d/%0d want 1/1", csLTotal - csL0, csHTotal - csH0); else nPass++;
  endtask

  task automatic test_byte_write();
    cpu_start(24'h3C0002, 1'b1, 16'h12AB, 1'b0, 1'b1);
    repeat (5) @(negedge C25M);
    bus.CPUSlot = 1'b1;
    @(posedge C25M); #1;
    bus.CPUSlot = 1'b0;
    nChecks++; if (bus.RA !== 17'h00001) $display("FAIL wr_RA: got %h want 00001", bus.RA); else nPass++;
    nChecks++; if (bus.RDout !== 16'h12AB) $display("FAIL wr_RDout: got %h want 12ab", bus.RDout); else nPass++;
    nChecks++; if ({bus.nRWE, bus.RDoe} !== 2'b01) $display("FAIL wr_setup: got nRWE/RDoe=%b want 01", {bus.nRWE, bus.RDoe}); else nPass++;
    @(posedge C25M); #1;
    nChecks++; if ({bus.nRCSL, bus.nRCSH, bus.nRWE} !== 3'b010) $display("FAIL wr_strobe: got nRCSL/nRCSH/nRWE=%b want 010", {bus.nRCSL, bus.nRCSH, bus.nRWE}); else nPass++;
    @(posedge C25M); #1;
    nChecks++; if ({bus.nRCSL, bus.nRCSH, bus.nRWE, bus.RDoe} !== 4'b1110) $display("FAIL wr_end: got %b want 1110", {bus.nRCSL, bus.nRCSH, bus.nRWE, bus.RDoe}); else nPass++;
    @(posedge C25M); #1;
    nChecks++; if ({bus.nDTACK, bus.Doe} !== 2'b00) $display("FAIL wr_dtack: got nDTACK/Doe=%b want 00", {bus.nDTACK, bus.Doe}); else nPass++;
    @(negedge C25M);
    cpu_end();
    repeat (5) @(posedge C25M); #1;
    nChecks++; if ({bus.nDTACK, bus.Busy} !== 2'b10) $display("FAIL wr_idle: got nDTACK/Busy=%b want 10", {bus.nDTACK, bus.Busy}); else nPass++;
  endtask

  task automatic test_miss();
    int csL0, csH0, dt0;
    csL0 = csLTotal;
    csH0 = csHTotal;
    dt0  = dtackTotal;
    cpu_start(24'h200000, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (6) @(negedge C25M);
    bus.CPUSlot = 1'b1;
    @(negedge C25M);
    bus.CPUSlot = 1'b0;
    repeat (4) @(posedge C25M); #1;
    nChecks++; if (bus.Busy !== 1'b1) $display("FAIL miss_Busy_mid: got %b want 1", bus.Busy); else nPass++;
    @(negedge C25M);
    cpu_end();
    repeat (5) @(posedge C25M); #1;
    nChecks++; if (bus.Busy !== 1'b0) $display("FAIL miss_Busy_end: got %b want 0", bus.Busy); else nPass++;
    nChecks++; if ((csLTotal - csL0) !== 0 || (csHTotal - csH0) !== 0) $display("FAIL miss_cs: got %0d/%0d want 0/0", csLTotal - csL0, csHTotal - csH0); else nPass++;
    nChecks++; if ((dtackTotal - dt0) !== 0) $display("FAIL miss_dtack: got %0d want 0", dtackTotal - dt0); else nPass++;
  endtask

  task automatic test_abort();
    int csL0, dt0;
    csL0 = csLTotal;
    dt0  = dtackTotal;
    cpu_start(24'h3FA700, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (5) @(negedge C25M);
    cpu_end();
    repeat (4) @(negedge C25M);
    bus.CPUSlot = 1'b1;
    @(negedge C25M);
    bus.CPUSlot = 1'b0;
    repeat (5) @(posedge C25M); #1;
    nChecks++; if ((csLTotal - csL0) !== 0 || (dtackTotal - dt0) !== 0) $display("FAIL abort_access: got cs=%0d dtack=%0d want 0/0", csLTotal - csL0, dtackTotal - dt0); else nPass++;
    nChecks++; if ({bus.Busy, bus.nRWE, bus.nBERR} !== 3'b011) $display("FAIL abort_idle: got Busy/nRWE/nBERR=%b want 011", {bus.Busy, bus.nRWE, bus.nBERR}); else nPass++;
  endtask

  task automatic test_reset_mid_cycle();
    int csL0;
    bus.RDin = 16'h1111;
    cpu_start(24'h3FA700, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (5) @(negedge C25M);
    bus.CPUSlot = 1'b1;
    @(negedge C25M);
    bus.CPUSlot = 1'b0;
    @(negedge C25M);
    // FSM is in STROBE with chip selects low
    nRST = 1'b0;
    #1;
    nChecks++; if ({bus.nRCSL, bus.nRCSH, bus.nRWE, bus.nDTACK, bus.Busy} !== 5'b11110) $display("FAIL rstmid_ctl: got %b want 11110", {bus.nRCSL, bus.nRCSH, bus.nRWE, bus.nDTACK, bus.Busy}); else nPass++;
    nChecks++; if ({bus.RA, bus.Dout} !== 33'd0) $display("FAIL rstmid_data: got RA=%h Dout=%h want 0/0", bus.RA, bus.Dout); else nPass++;
    cpu_end();
    @(negedge C25M);
    nRST = 1'b1;
    repeat (3) @(negedge C25M);
    csL0 = csLTotal;
    bus.RDin = 16'h5A5A;
    cpu_start(24'h3C1234, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (5) @(negedge C25M);
    bus.CPUSlot = 1'b1;
    @(posedge C25M); #1;
    bus.CPUSlot = 1'b0;
    nChecks++; if (bus.RA !== 17'h0091A) $display("FAIL rstmid_next_RA: got %h want 0091a", bus.RA); else nPass++;
    repeat (3) @(posedge C25M); #1;
    nChecks++; if ({bus.nDTACK, bus.Dout} !== {1'b0, 16'h5A5A}) $display("FAIL rstmid_next_read: got %b/%h want 0/5a5a", bus.nDTACK, bus.Dout); else nPass++;
    nChecks++; if ((csLTotal - csL0) !== 1) $display("FAIL rstmid_next_cs: got %0d want 1", csLTotal - csL0); else nPass++;
    @(negedge C25M);
    cpu_end();
    repeat (5) @(negedge C25M);
  endtask

`ifdef RESP_TIMEOUT_EN
  task automatic test_timeout();
    int csL0;
    csL0 = csLTotal;
    cpu_start(24'h3FA700, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (67) @(posedge C25M); #1;
    nChecks++; if (bus.nBERR !== 1'b1) $display("FAIL to_early: got %b want 1", bus.nBERR); else nPass++;
    @(posedge C25M); #1;
    nChecks++; if ({bus.nBERR, bus.nDTACK} !== 2'b01) $display("FAIL to_berr: got nBERR/nDTACK=%b want 01", {bus.nBERR, bus.nDTACK}); else nPass++;
    @(negedge C25M);
    cpu_end();
    repeat (4) @(posedge C25M); #1;
    nChecks++; if (bus.nBERR !== 1'b1) $display("FAIL to_release: got %b want 1", bus.nBERR); else nPass++;
    nChecks++; if ((csLTotal - csL0) !== 0) $display("FAIL to_cs: got %0d want 0", csLTotal - csL0); else nPass++;
  endtask
`else
  task automatic test_slow_slot();
    bus.RDin = 16'hC3A5;
    cpu_start(24'h3C0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (90) @(negedge C25M);
    nChecks++; if ({bus.nBERR, bus.nDTACK, bus.Busy} !== 3'b111) $display("FAIL slow_wait: got nBERR/nDTACK/Busy=%b want 111", {bus.nBERR, bus.nDTACK, bus.Busy}); else nPass++;
    bus.CPUSlot = 1'b1;
    @(posedge C25M); #1;
    bus.CPUSlot = 1'b0;
    nChecks++; if (bus.RA !== 17'h00000) $display("FAIL slow_RA: got %h want 00000", bus.RA); else nPass++;
    repeat (3) @(posedge C25M); #1;
    nChecks++; if ({bus.nDTACK, bus.Dout} !== {1'b0, 16'hC3A5}) $display("FAIL slow_read: got %b/%h want 0/c3a5", bus.nDTACK, bus.Dout); else nPass++;
    @(negedge C25M);
    cpu_end();
    repeat (5) @(negedge C25M);
  endtask
`endif

  initial begin
    nChecks     = 0;
    nPass       = 0;
    nRST        = 1'b0;
    bus.A       = '0;
    bus.Din     = '0;
    bus.nAS     = 1'b1;
    bus.nLDS    = 1'b1;
    bus.nUDS    = 1'b1;
    bus.nWE     = 1'b1;
    bus.CPUSlot = 1'b0;
    bus.RDin    = '0;
    test_reset();
    test_read_hit();
    test_byte_write();
    test_miss();
    test_abort();
    test_reset_mid_cycle();
`ifdef RESP_TIMEOUT_EN
    test_timeout();
`else
    test_slow_slot();
`endif
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", nPass, nChecks);
    $fatal(1);
  end

endmodule
`default_nettype wire
